// File: rtl/div_arbiter.sv
// Round-robin front end that shares one long-division unit between two requesters.
// Sequences the divider start/done handshake and aborts a hung divider with a watchdog.
module div_arbiter #(
  parameter int SIZE    = 8,
  parameter int TIMEOUT = 40
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [1:0]      i_req,
  input  logic [SIZE-1:0] i_dividend0,
  input  logic [SIZE-1:0] i_divisor0,
  input  logic [SIZE-1:0] i_dividend1,
  input  logic [SIZE-1:0] i_divisor1,
  output logic [1:0]      o_ack,
  output logic [1:0]      o_rsp_valid,
  output logic [SIZE-1:0] o_rsp_quotient,
  output logic [SIZE-1:0] o_rsp_remainder,
  output logic            o_rsp_error,
  output logic            o_rsp_timeout,
  output logic            o_busy,
  output logic            o_div_rst,
  output logic            o_div_start,
  output logic [SIZE-1:0] o_div_dividend,
  output logic [SIZE-1:0] o_div_divisor,
  input  logic            i_div_done,
  input  logic            i_div_error,
  input  logic [SIZE-1:0] i_div_quotient,
  input  logic [SIZE-1:0] i_div_remainder
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_ABORT,
    S_RESPOND
  } state_t;

  localparam logic [7:0] WDOG_LOAD = 8'(TIMEOUT);

  state_t          r_state;
  state_t          w_next;
  logic            r_id;
  logic            r_lastGrant;
  logic [7:0]      r_wdog;
  logic [SIZE-1:0] r_dividend;
  logic [SIZE-1:0] r_divisor;
  logic [SIZE-1:0] r_quotient;
  logic [SIZE-1:0] r_remainder;
  logic            r_error;
  logic            r_timeout;
  logic            w_grantId;

  // With both requests pending, the one not served last time wins.
  always_comb begin
    w_grantId = 1'b0;
    case (i_req)
      2'b10:   w_grantId = 1'b1;
      2'b11:   w_grantId = ~r_lastGrant;
      default: w_grantId = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_req != 2'b00) w_next = S_LAUNCH;
      S_LAUNCH:  w_next = S_BUSY;
      S_BUSY: begin
        if (i_div_done)          w_next = S_RESPOND;
        else if (r_wdog == 8'd0) w_next = S_ABORT;
      end
      S_ABORT:   w_next = S_RESPOND;
      S_RESPOND: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Operand latch, watchdog and response registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_id        <= 1'b0;
      r_lastGrant <= 1'b1;
      r_wdog      <= 8'd0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_error     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req != 2'b00) begin
            r_id        <= w_grantId;
            r_lastGrant <= w_grantId;
            r_dividend  <= w_grantId ? i_dividend1 : i_dividend0;
            r_divisor   <= w_grantId ? i_divisor1  : i_divisor0;
          end
        end
        S_LAUNCH: r_wdog <= WDOG_LOAD;
        S_BUSY: begin
          if (i_div_done) begin
            r_quotient  <= i_div_quotient;
            r_remainder <= i_div_remainder;
            r_error     <= i_div_error;
            r_timeout   <= 1'b0;
          end else if (r_wdog != 8'd0) begin
            r_wdog <= r_wdog - 8'd1;
          end
        end
        S_ABORT: begin
          r_quotient  <= '0;
          r_remainder <= '0;
          r_error     <= 1'b1;
          r_timeout   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_ack           = (r_state == S_LAUNCH)  ? (r_id ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_valid     = (r_state == S_RESPOND) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
  assign o_div_start     = (r_state == S_LAUNCH);
  assign o_busy          = (r_state != S_IDLE);
  assign o_div_rst       = i_reset | (r_state == S_ABORT);
  assign o_div_dividend  = r_dividend;
  assign o_div_divisor   = r_divisor;
  assign o_rsp_quotient  = r_quotient;
  assign o_rsp_remainder = r_remainder;
  assign o_rsp_error     = r_error;
  assign o_rsp_timeout   = r_timeout;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural divider stub of programmable latency.
// Expected responses are queued when a request is driven and popped when rsp_valid fires.
module tb_div_arbiter;

  localparam int SIZE    = 8;
  localparam int TIMEOUT = 40;

  typedef struct {
    logic       id;
    logic [7:0] q;
    logic [7:0] r;
    logic       err;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [7:0] divd0, divs0, divd1, divs1;
  logic [1:0] ack, rspValid;
  logic [7:0] rspQ, rspR;
  logic       rspErr, rspTo, busy, divRst, divStart;
  logic [7:0] divDividend, divDivisor;
  logic       divDone, divError;
  logic [7:0] divQ, divR;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  int   stubLatency = 0;
  int   stubCnt = 0;
  bit   stubPending = 0;

  div_arbiter #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req),
    .i_dividend0(divd0), .i_divisor0(divs0),
    .i_dividend1(divd1), .i_divisor1(divs1),
    .o_ack(ack), .o_rsp_valid(rspValid),
    .o_rsp_quotient(rspQ), .o_rsp_remainder(rspR),
    .o_rsp_error(rspErr), .o_rsp_timeout(rspTo),
    .o_busy(busy), .o_div_rst(divRst), .o_div_start(divStart),
    .o_div_dividend(divDividend), .o_div_divisor(divDivisor),
    .i_div_done(divDone), .i_div_error(divError),
    .i_div_quotient(divQ), .i_div_remainder(divR)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic id, logic [7:0] a, logic [7:0] b);
    exp_t e;
    e.id = id;
    e.to = 1'b0;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.err = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.err = 1'b0;
    end
    return e;
  endfunction

  // Divider stub: done arrives `stubLatency` cycles after start; 0 means it hangs.
  initial begin
    divDone = 0; divError = 0; divQ = 8'hA5; divR = 8'h5A;
    forever begin
      @(negedge clk);
      divDone = 0; divError = 0; divQ = 8'hA5; divR = 8'h5A;
      if (divRst) stubPending = 0;
      else if (stubPending) begin
        stubCnt--;
        if (stubCnt == 0) begin
          stubPending = 0;
          divDone = 1;
          if (divDivisor == 8'd0) begin
            divError = 1; divQ = 8'hFF; divR = divDividend;
          end else begin
            divQ = divDividend / divDivisor; divR = divDividend % divDivisor;
          end
        end
      end else if (divStart && stubLatency > 0) begin
        stubPending = 1;
        stubCnt = stubLatency;
      end
    end
  end

  // Response monitor and handshake exclusivity checks.
  always @(negedge clk) begin
    if ((ack | rspValid) != 2'b00) begin
      vectors++;
      if (((ack != 2'b00) && (rspValid != 2'b00)) || ack === 2'b11 || rspValid === 2'b11) begin
        miscompares++;
        $display("[TB] FAIL handshake_exclusive: ack=%b rsp_valid=%b, want at most one bit of one", ack, rspValid);
      end
    end
    if (rspValid != 2'b00) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_rsp: rsp_valid=%b with empty scoreboard, want none", rspValid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rspValid !== (e.id ? 2'b10 : 2'b01) || rspQ !== e.q || rspR !== e.r ||
            rspErr !== e.err || rspTo !== e.to) begin
          miscompares++;
          $display("[TB] FAIL rsp_check: got valid=%b q=%0d r=%0d err=%b to=%b, want valid=%b q=%0d r=%0d err=%b to=%b",
                   rspValid, rspQ, rspR, rspErr, rspTo, (e.id ? 2'b10 : 2'b01), e.q, e.r, e.err, e.to);
        end
      end
    end
  end

  task automatic applyStimulus(input logic id, input logic [7:0] a, input logic [7:0] b);
    if (id) begin divd1 = a; divs1 = b; end
    else    begin divd0 = a; divs0 = b; end
    req[id] = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1; req = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 0 || ack !== 0 || rspValid !== 0 || divStart !== 0 || divRst !== 1 ||
        rspQ !== 0 || rspR !== 0 || rspErr !== 0 || rspTo !== 0 || divDividend !== 0 || divDivisor !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: busy=%b ack=%b rv=%b start=%b drst=%b q=%0d r=%0d e=%b t=%b dd=%0d ds=%0d, want drst=1 rest 0",
               busy, ack, rspValid, divStart, divRst, rspQ, rspR, rspErr, rspTo, divDividend, divDivisor);
    end
    reset = 0;
    @(negedge clk);
    vectors++;
    if (divRst !== 0 || busy !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: div_rst=%b busy=%b, want 0 0", divRst, busy);
    end
  endtask

  task automatic test_basic();
    int n;
    stubLatency = 5;
    sb.push_back(mk(1'b0, 8'd100, 8'd7));
    applyStimulus(1'b0, 8'd100, 8'd7);
    @(negedge clk);
    vectors++;
    if (ack !== 2'b01 || divStart !== 1 || divDividend !== 8'd100 || divDivisor !== 8'd7 || busy !== 1) begin
      miscompares++;
      $display("[TB] FAIL basic_launch: ack=%b start=%b dd=%0d ds=%0d busy=%b, want 01 1 100 7 1",
               ack, divStart, divDividend, divDivisor, busy);
    end
    req[0] = 0;
    n = 0;
    while (rspValid === 2'b00 && n < 100) begin @(negedge clk); n++; end
    vectors++;
    if (n !== 6) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: rsp after %0d cycles, want 6", n);
    end
    @(negedge clk);
  endtask

  task automatic test_divzero();
    int n;
    stubLatency = 3;
    sb.push_back(mk(1'b1, 8'd9, 8'd0));
    applyStimulus(1'b1, 8'd9, 8'd0);
    @(negedge clk);
    vectors++;
    if (ack !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL divzero_ack: ack=%b, want 10", ack);
    end
    req[1] = 0;
    n = 0;
    while (rspValid === 2'b00 && n < 100) begin @(negedge clk); n++; end
    vectors++;
    if (rspValid !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL divzero_rsp: rsp_valid=%b, want 10", rspValid);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    stubLatency = 4;
    sb.push_back(mk(1'b0, 8'd200, 8'd10));
    sb.push_back(mk(1'b1, 8'd255, 8'd16));
    applyStimulus(1'b0, 8'd200, 8'd10);
    applyStimulus(1'b1, 8'd255, 8'd16);
    @(negedge clk);
    vectors++;
    if (ack !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL rr_first: ack=%b, want 01", ack);
    end
    req[0] = 0;
    n = 0;
    while (rspValid === 2'b00 && n < 100) begin @(negedge clk); n++; end
    sb.push_back(mk(1'b0, 8'd50, 8'd3));
    applyStimulus(1'b0, 8'd50, 8'd3);
    n = 0;
    while (ack === 2'b00 && n < 10) begin @(negedge clk); n++; end
    vectors++;
    if (ack !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL rr_second: ack=%b, want 10", ack);
    end
    req[1] = 0;
    n = 0;
    while (rspValid === 2'b00 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (ack === 2'b00 && n < 10) begin @(negedge clk); n++; end
    vectors++;
    if (ack !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL rr_third: ack=%b, want 01", ack);
    end
    req[0] = 0;
    n = 0;
    while (rspValid === 2'b00 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int   n, rstAt, rstCount;
    exp_t e;
    stubLatency = 0;
    e.id = 1'b0; e.q = 8'd0; e.r = 8'd0; e.err = 1'b1; e.to = 1'b1;
    sb.push_back(e);
    applyStimulus(1'b0, 8'd77, 8'd5);
    @(negedge clk);
    req[0] = 0;
    n = 0; rstAt = -1; rstCount = 0;
    while (rspValid === 2'b00 && n < 100) begin
      @(negedge clk); n++;
      if (divRst === 1'b1) begin
        rstCount++;
        if (rstAt < 0) rstAt = n;
      end
    end
    vectors++;
    if (rstAt !== TIMEOUT + 2 || rstCount !== 1 || n !== TIMEOUT + 3) begin
      miscompares++;
      $display("[TB] FAIL timeout_abort: div_rst at %0d count %0d rsp at %0d, want %0d 1 %0d",
               rstAt, rstCount, n, TIMEOUT + 2, TIMEOUT + 3);
    end
    @(negedge clk);
    stubLatency = 3;
    sb.push_back(mk(1'b1, 8'd50, 8'd5));
    applyStimulus(1'b1, 8'd50, 8'd5);
    @(negedge clk);
    vectors++;
    if (ack !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL timeout_recover_ack: ack=%b, want 10", ack);
    end
    req[1] = 0;
    n = 0;
    while (rspValid === 2'b00 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  task automatic test_coincident();
    int n, rstCount;
    stubLatency = TIMEOUT + 1;
    sb.push_back(mk(1'b0, 8'd81, 8'd9));
    applyStimulus(1'b0, 8'd81, 8'd9);
    @(negedge clk);
    req[0] = 0;
    n = 0; rstCount = 0;
    while (rspValid === 2'b00 && n < 100) begin
      @(negedge clk); n++;
      if (divRst === 1'b1) rstCount++;
    end
    vectors++;
    if (rstCount !== 0 || n !== TIMEOUT + 2) begin
      miscompares++;
      $display("[TB] FAIL coincident_done: div_rst count %0d rsp at %0d, want 0 %0d", rstCount, n, TIMEOUT + 2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midbusy();
    int n;
    stubLatency = 30;
    applyStimulus(1'b0, 8'd10, 8'd2);
    @(negedge clk);
    req[0] = 0;
    repeat (5) @(negedge clk);
    reset = 1;
    @(negedge clk);
    vectors++;
    if (busy !== 0 || ack !== 0 || rspValid !== 0 || divStart !== 0 || divRst !== 1 ||
        rspQ !== 0 || rspR !== 0 || rspErr !== 0 || rspTo !== 0 || divDividend !== 0 || divDivisor !== 0) begin
      miscompares++;
      $display("[TB] FAIL midbusy_reset: busy=%b ack=%b rv=%b start=%b drst=%b q=%0d r=%0d e=%b t=%b dd=%0d ds=%0d, want drst=1 rest 0",
               busy, ack, rspValid, divStart, divRst, rspQ, rspR, rspErr, rspTo, divDividend, divDivisor);
    end
    reset = 0;
    repeat (40) @(negedge clk);
    vectors++;
    if (busy !== 0 || divRst !== 0) begin
      miscompares++;
      $display("[TB] FAIL midbusy_quiet: busy=%b div_rst=%b, want 0 0", busy, divRst);
    end
    stubLatency = 2;
    sb.push_back(mk(1'b0, 8'd12, 8'd4));
    sb.push_back(mk(1'b1, 8'd14, 8'd7));
    applyStimulus(1'b0, 8'd12, 8'd4);
    applyStimulus(1'b1, 8'd14, 8'd7);
    @(negedge clk);
    vectors++;
    if (ack !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL post_reset_first: ack=%b, want 01", ack);
    end
    req[0] = 0;
    n = 0;
    while (rspValid === 2'b00 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (ack === 2'b00 && n < 10) begin @(negedge clk); n++; end
    vectors++;
    if (ack !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL post_reset_second: ack=%b, want 10", ack);
    end
    req[1] = 0;
    n = 0;
    while (rspValid === 2'b00 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  task automatic checkOutput();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d responses outstanding, want 0", sb.size());
    end
  endtask

  initial begin
    reset = 1; req = 0;
    divd0 = 0; divs0 = 0; divd1 = 0; divs1 = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_divzero();
    test_back_to_back();
    test_timeout();
    test_coincident();
    test_reset_midbusy();
    checkOutput();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one long-division unit (divider FSM plus datapath, operand width SIZE) between two requesters.
- Arbitrates requests round-robin and latches the winner's operands.
- Sequences the divider's start/done handshake and routes the quotient, remainder and error back to the requester that was granted.
- Includes a watchdog that resets a hung divider and returns an error response.
- Sits between client logic and the divider instance at the same level of the top module.

Parameters:
SIZE, 8, operand/result width in bits
TIMEOUT, 40, max cycles in BUSY waiting for div_done before abort (1..255)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req  input  2  req[i] high = requester i has a pending operation; held until ack[i]
dividend0  input  SIZE  requester 0 dividend; stable while req[0] high
divisor0  input  SIZE  requester 0 divisor; stable while req[0] high
dividend1  input  SIZE  requester 1 dividend
divisor1  input  SIZE  requester 1 divisor
ack  output  2  one-cycle pulse; request i accepted, operands captured
rsp_valid  output  2  one-cycle pulse; response for requester i on rsp_* bus
rsp_quotient  output  SIZE  result quotient
rsp_remainder  output  SIZE  result remainder
rsp_error  output  1  divide-by-zero or timeout
rsp_timeout  output  1  response produced by watchdog abort
busy  output  1  high in any state other than IDLE
div_rst  output  1  divider reset = reset OR watchdog abort pulse
div_start  output  1  one-cycle start pulse to divider
div_dividend  output  SIZE  latched dividend, held from grant through BUSY
div_divisor  output  SIZE  latched divisor, held from grant through BUSY
div_done  input  1  divider completion (one cycle, with or without error)
div_error  input  1  divider error, qualified by div_done
div_quotient  input  SIZE  divider quotient, qualified by div_done
div_remainder  input  SIZE  divider remainder, qualified by div_done

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE; ack, rsp_valid, div_start = 0; rsp_* = 0; div_* operand registers = 0; last_grant = 1, so requester 0 wins first; watchdog counter = 0.
- div_rst is combinational: high during reset and in the ABORT cycle.
- IDLE:
  - If req != 0, grant and go to LAUNCH.
  - Grant rule: only one request high → that one. Both high → the requester other than last_grant.
  - On the grant edge: latch the winner's operands into div_dividend/div_divisor; record grant id; update last_grant.
- LAUNCH:
  - ack[id]=1 and div_start=1 for exactly this cycle.
  - Load watchdog with TIMEOUT; go to BUSY.
- BUSY:
  - Watchdog decrements each cycle.
  - div_done=1 → capture div_quotient, div_remainder, div_error into rsp_*; rsp_timeout=0; go to RESPOND.
  - Else watchdog==0 → go to ABORT.
  - div_done and watchdog==0 in the same cycle → div_done wins.
- ABORT (1 cycle):
  - div_rst=1.
  - Set rsp_quotient=0, rsp_remainder=0, rsp_error=1, rsp_timeout=1; go to RESPOND.
- RESPOND (1 cycle):
  - rsp_valid[id]=1; rsp_* stable; go to IDLE.
  - rsp_* hold their values until the next capture.
- Throughput: no new grant is made until IDLE is re-entered, i.e. one operation in flight.
- Latency: request seen in IDLE → ack 1 cycle later; rsp_valid 1 cycle after the div_done cycle.
- Request rules:
  - A requester must drop req the cycle after ack or it is re-arbitrated as a new request.
  - req dropped before ack: not a legal stimulus, but the block still completes any already-latched operation and responds.
  - Requests arriving while busy wait, unlost, as long as req is held.
- Reset in any state: immediate return to IDLE next edge. No rsp_valid is emitted for the aborted operation; div_rst asserts with reset.
- ack and rsp_valid are never both high. At most one bit of each is high at a time.

Test Plan:
- req[0] with 100/7 → ack[0] 1 cycle after req; div_start pulse; after div_done, rsp_valid[0], quotient=14, remainder=2, error=0, timeout=0.
- req[1] with 9/0 → rsp_valid[1] with rsp_error=1, rsp_timeout=0; no other rsp_valid bit asserted.
- req=2'b11 held (0: 200/10, 1: 255/16), then requester 0 re-requests immediately → grant order 0, 1, 0; responses 20r0 then 15r15, no starvation.
- Divider model never asserts div_done → after TIMEOUT=40 BUSY cycles, div_rst pulses 1 cycle, then rsp_valid[id] with error=1, timeout=1, quotient=0; next request then completes normally.
- div_done coincident with watchdog==0 → normal result returned, rsp_timeout=0, no div_rst pulse.
- reset asserted mid-BUSY → next cycle busy=0, all outputs 0, no rsp_valid; a following req=2'b11 grants requester 0 first.
